// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizing for the multi-port register file
package regfile_pkg;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;
  localparam int XLEN_D = 32;
  localparam int NREGS_D = 32;
  localparam int NRD_D = 2;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port with zero-register check and write forwarding
module regfile_rdport #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            en,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic [1:0]      wr_ena,
  input  logic [2*AW-1:0] wr_addr,
  input  logic [2*XLEN-1:0] wr_data,
  output logic [XLEN-1:0] data
);
  logic hit0, hit1;
  // forward the in-flight write, port 1 first; address 0 and idle/init cycles read as zero
  always_comb begin
    hit1 = BYPASS != 0 && wr_ena[1] && wr_addr[AW +: AW] == addr;
    hit0 = BYPASS != 0 && wr_ena[0] && wr_addr[0 +: AW] == addr;
    data = (!en || addr == '0) ? '0 :
           hit1 ? wr_data[XLEN +: XLEN] :
           hit0 ? wr_data[0 +: XLEN] : regs[addr];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with a post-reset clearing sweep
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int NRD = NRD_D,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] read_addr,
  output logic [NRD*XLEN-1:0] read_data,
  input  logic [1:0]        write_ena,
  input  logic [2*AW-1:0]   write_addr,
  input  logic [2*XLEN-1:0] data_in,
  output logic              init_done
);
  state_e state;
  logic [AW-1:0] sweep;
  logic [XLEN-1:0] regs [NREGS];
  logic run;
  logic [1:0] wr_ena;
  assign run = state == RUN && !rst;
  assign init_done = state == RUN;
  // writes to register 0, during the sweep or under reset are dropped before arbitration
  always_comb begin
    wr_ena[0] = write_ena[0] && run && write_addr[0 +: AW] != '0;
    wr_ena[1] = write_ena[1] && run && write_addr[AW +: AW] != '0;
  end
  // sweep counter walks 1..NREGS-1 then hands over to RUN for good
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      sweep <= AW'(1);
    end else if (state == INIT) begin
      sweep <= sweep + 1'b1;
      if (sweep == AW'(NREGS - 1)) state <= RUN;
    end
  end
  // storage: clear one register per sweep cycle, then commit writes with port 1 last so it wins
  always_ff @(posedge clk) begin
    if (rst) regs[0] <= '0;
    else if (state == INIT) regs[sweep] <= '0;
    else begin
      if (wr_ena[0]) regs[write_addr[0 +: AW]] <= data_in[0 +: XLEN];
      if (wr_ena[1]) regs[write_addr[AW +: AW]] <= data_in[XLEN +: XLEN];
    end
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_rd (
      .en(run),
      .addr(read_addr[i*AW +: AW]),
      .regs(regs),
      .wr_ena(wr_ena),
      .wr_addr(write_addr),
      .wr_data(data_in),
      .data(read_data[i*XLEN +: XLEN])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector bench for regfile_mp (bypass, no-bypass and wide/4-port builds)
module tb_regfile_mp;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic [9:0]  read_addr, write_addr;
  logic [1:0]  write_ena;
  logic [63:0] data_in, rd_b, rd_n;
  logic        done_b, done_n;
  logic [15:0]  p_ra;
  logic [255:0] p_rd;
  logic [1:0]   p_we;
  logic [7:0]   p_wa;
  logic [127:0] p_din;
  logic         p_done;
  regfile_mp u_b (.clk(clk), .rst(rst), .read_addr(read_addr), .read_data(rd_b), .write_ena(write_ena),
                  .write_addr(write_addr), .data_in(data_in), .init_done(done_b));
  regfile_mp #(.BYPASS(0)) u_n (.clk(clk), .rst(rst), .read_addr(read_addr), .read_data(rd_n), .write_ena(write_ena),
                  .write_addr(write_addr), .data_in(data_in), .init_done(done_n));
  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4)) u_p (.clk(clk), .rst(rst), .read_addr(p_ra), .read_data(p_rd),
                  .write_ena(p_we), .write_addr(p_wa), .data_in(p_din), .init_done(p_done));
  typedef struct packed {
    logic [1:0] we;
    logic [4:0] wa0, wa1;
    logic [31:0] d0, d1;
    logic [4:0] ra0, ra1;
    logic [31:0] b0, b1, n0, n1;
  } vec_t;
  vec_t tv [15];
  int vecs = 0;
  int errs = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drv(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [4:0] ra0, input logic [4:0] ra1);
    write_ena = we;
    write_addr = {wa1, wa0};
    data_in = {d1, d0};
    read_addr = {ra1, ra0};
  endtask
  task automatic next_cycle();
    @(negedge clk);
    #2;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nb, np;
    tv[0]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd2, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[1]  = '{2'b01, 5'd1, 5'd0, 32'h114beef, 32'h0, 5'd1, 5'd2, 32'h114beef, 32'h0, 32'h0, 32'h0};
    tv[2]  = '{2'b01, 5'd2, 5'd0, 32'hff1ce11, 32'h0, 5'd1, 5'd2, 32'h114beef, 32'hff1ce11, 32'h114beef, 32'h0};
    tv[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd2, 32'h114beef, 32'hff1ce11, 32'h114beef, 32'hff1ce11};
    tv[4]  = '{2'b11, 5'd0, 5'd0, 32'h1111111, 32'h1111111, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[6]  = '{2'b10, 5'd0, 5'd7, 32'h0, 32'h77, 5'd7, 5'd1, 32'h77, 32'h114beef, 32'h0, 32'h114beef};
    tv[7]  = '{2'b11, 5'd7, 5'd7, 32'hAAAA, 32'hBBBB, 5'd7, 5'd7, 32'hBBBB, 32'hBBBB, 32'h77, 32'h77};
    tv[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd2, 32'hBBBB, 32'hff1ce11, 32'hBBBB, 32'hff1ce11};
    tv[9]  = '{2'b11, 5'd3, 5'd4, 32'h333, 32'h444, 5'd4, 5'd3, 32'h444, 32'h333, 32'h0, 32'h0};
    tv[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd4, 32'h333, 32'h444, 32'h333, 32'h444};
    tv[11] = '{2'b10, 5'd3, 5'd3, 32'h111, 32'h999, 5'd3, 5'd4, 32'h999, 32'h444, 32'h333, 32'h444};
    tv[12] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0, 32'h999, 32'h0, 32'h999, 32'h0};
    tv[13] = '{2'b11, 5'd5, 5'd6, 32'h5555, 32'h6666, 5'd5, 5'd6, 32'h5555, 32'h6666, 32'h0, 32'h0};
    tv[14] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd6, 5'd5, 32'h6666, 32'h5555, 32'h6666, 32'h5555};
    drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd3);
    p_we = 2'b00; p_wa = '0; p_din = '0; p_ra = {4'd3, 4'd2, 4'd1, 4'd5};
    next_cycle();
    chk("rst_read_b", rd_b, 64'h0);
    chk("rst_read_p", p_rd[63:0], 64'h0);
    chk("rst_done", {63'h0, done_b}, 64'h0);
    rst = 0;
    nb = 0;
    np = 0;
    for (int c = 0; c < 100 && !done_b; c++) begin
      nb++;
      if (!p_done) np++;
      if (c == 10) drv(2'b01, 5'd5, 5'd0, 32'h1234, 32'h0, 5'd5, 5'd3);
      if (c == 11) drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd3);
      #1;
      chk($sformatf("init_read c%0d", c), rd_b, 64'h0);
      #1;
      next_cycle();
    end
    chk("init_done_b", {63'h0, done_b}, 64'h1);
    chk("init_done_n", {63'h0, done_n}, 64'h1);
    chk("sweep_len", 64'(nb), 64'd31);
    chk("sweep_len_p", 64'(np), 64'd15);
    for (int i = 0; i < 15; i++) begin
      drv(tv[i].we, tv[i].wa0, tv[i].wa1, tv[i].d0, tv[i].d1, tv[i].ra0, tv[i].ra1);
      #1;
      chk($sformatf("v%0d bypass", i), rd_b, {tv[i].b1, tv[i].b0});
      chk($sformatf("v%0d nobypass", i), rd_n, {tv[i].n1, tv[i].n0});
      next_cycle();
    end
    p_we = 2'b11; p_wa = {4'd2, 4'd1}; p_din = {64'haaaa_bbbb_cccc_dddd, 64'h1111_2222_3333_4444};
    next_cycle();
    p_wa = {4'd15, 4'd9}; p_din = {64'hf0f0_0f0f_f00f_0ff0, 64'h9999_8888_7777_6666};
    next_cycle();
    p_we = 2'b00; p_ra = {4'd15, 4'd9, 4'd2, 4'd1};
    #1;
    chk("p_rd0", p_rd[63:0], 64'h1111_2222_3333_4444);
    chk("p_rd1", p_rd[127:64], 64'haaaa_bbbb_cccc_dddd);
    chk("p_rd2", p_rd[191:128], 64'h9999_8888_7777_6666);
    chk("p_rd3", p_rd[255:192], 64'hf0f0_0f0f_f00f_0ff0);
    next_cycle();
    for (int a = 1; a < 32; a++) begin
      drv(2'b01, 5'(a), 5'd0, 32'(a), 32'h0, 5'd0, 5'd0);
      next_cycle();
    end
    drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd17);
    #1;
    chk("fill_b", rd_b, {32'd17, 32'd31});
    chk("fill_n", rd_n, {32'd17, 32'd31});
    next_cycle();
    rst = 1;
    drv(2'b01, 5'd9, 5'd0, 32'habc, 32'h0, 5'd9, 5'd31);
    #1;
    chk("midrst_read", rd_b, 64'h0);
    next_cycle();
    rst = 0;
    drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd31);
    for (int c = 0; c < 100 && !done_b; c++) next_cycle();
    chk("midrst_done", {63'h0, done_b}, 64'h1);
    for (int a = 1; a < 32; a++) begin
      drv(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'(a), 5'(32 - a));
      #1;
      chk($sformatf("cleared_b a%0d", a), rd_b, 64'h0);
      chk($sformatf("cleared_n a%0d", a), rd_n, 64'h0);
      next_cycle();
    end
    p_ra = {4'd15, 4'd9, 4'd2, 4'd1};
    #1;
    chk("cleared_p", p_rd[255:128] | p_rd[127:0], 128'h0);
    chk("cleared_p_done", {63'h0, p_done}, 64'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREGS, default 32: register count (power of 2, >=4); AW = log2(NREGS).
REQ-003 Parameter NRD, default 2: number of read ports (1..4).
REQ-004 Parameter BYPASS, default 1: 1 = write-to-read forwarding; 0 = read returns the stored value only.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 read_addr  in  NRD*AW  packed read addresses; port i occupies [i*AW +: AW].
REQ-008 read_data  out  NRD*XLEN  packed read data; port i occupies [i*XLEN +: XLEN].
REQ-009 write_ena  in  2  per-write-port enable.
REQ-010 write_addr  in  2*AW  packed write addresses, port j at [j*AW +: AW].
REQ-011 data_in  in  2*XLEN  packed write data, port j at [j*XLEN +: XLEN].
REQ-012 init_done  out  1  high once the clear sweep has completed; writes are accepted only while it is high.

Function
REQ-013 The block SHALL implement FSM states INIT and RUN.
REQ-014 INIT: a sweep counter SHALL clear register idx (from 1 through NREGS-1) to 0, one register per cycle; init_done=0.
REQ-015 INIT->RUN on the cycle the counter clears NREGS-1; init_done SHALL rise on the following edge, so the sweep lasts NREGS-1 cycles.
REQ-016 RUN is terminal until rst.
REQ-017 In INIT, write_ena SHALL be ignored, and every read_data SHALL be 0.
REQ-018 Reads SHALL be combinational: read_data[i] = reg[read_addr[i]] in the same cycle.
REQ-019 Address 0 SHALL always read 0; writes to address 0 SHALL be discarded, with no forwarding.
REQ-020 In RUN, an enabled write SHALL update the register on the rising edge; the new value is visible in the next cycle.
REQ-021 Both write ports enabled to the same nonzero address: port 1 SHALL win; port 0's data is dropped.
REQ-022 Both write ports to different addresses SHALL both commit in the same cycle.
REQ-023 BYPASS=1: a read matching an enabled write address (nonzero, RUN) SHALL return that write's data_in in the same cycle, with port 1 taking priority over port 0.
REQ-024 BYPASS=0: a read in the write cycle SHALL return the old value.
REQ-025 Out-of-range behaviour SHALL NOT exist: all AW-bit addresses are valid.

Reset
REQ-026 rst high at a rising edge SHALL force state INIT, sweep counter=1, init_done=0; register 0 is constant 0.
REQ-027 rst asserted mid-sweep or mid-RUN SHALL restart the full sweep; writes in progress that cycle SHALL be discarded.
REQ-028 While rst is high, read_data SHALL be 0 for all ports.

Structure
REQ-029 A shared package regfile_pkg SHALL hold the state enum (INIT, RUN) and default parameter constants (XLEN_D=32, NREGS_D=32, NRD_D=2).
REQ-030 One sub-module, regfile_rdport (a single read mux with zero-check and bypass compare), SHALL be instantiated NRD times via generate.
REQ-031 Register storage, the FSM and write arbitration SHALL live in regfile_mp.

Verification
REQ-032 Reset scenario: rst=1 for 1 cycle, then 0 -> init_done=0 for exactly 31 cycles and high on cycle 32 (defaults); a write to addr 5 of 32'h1234 during the sweep -> reg5 reads 0 after init.
REQ-033 Basic write/read scenario: write 32'h114beef to addr 1 and 32'hff1ce11 to addr 2 via port 0 in consecutive cycles -> next cycles read_addr={2,1} returns {32'hff1ce11, 32'h114beef}.
REQ-034 Zero-register scenario: write 32'h1111111 to addr 0 on both ports -> read addr 0 = 0 on all ports, including in the same cycle with BYPASS=1.
REQ-035 Write-conflict scenario: port0 writes addr 7 = 32'hAAAA, port1 writes addr 7 = 32'hBBBB, same cycle -> addr 7 reads 32'hBBBB; concurrent read of addr 7 that cycle = 32'hBBBB (BYPASS=1) or the old value (BYPASS=0).
REQ-036 Mid-operation reset scenario: fill addrs 1..31 with their index, then pulse rst -> after the sweep, all addrs read 0.
REQ-037 Parameter scenario: run with XLEN=64, NREGS=16, NRD=4 -> sweep lasts 15 cycles, and 4 simultaneous reads of distinct written regs return the correct 64-bit values.
